// File: rtl/dtcm_pkg.sv
// dtcm_pkg: shared constants, bus payload types and helpers for the data-TCM arbiter.
//   N_PORTS / PORT_LSU / PORT_DBG : requester port indices
//   tcm_req_t                     : muxed request towards the TCM
//   tcm_rsp_t                     : registered response towards the requesters
package dtcm_pkg;

    localparam int unsigned N_PORTS    = 2;
    localparam int unsigned PORT_LSU   = 0;
    localparam int unsigned PORT_DBG   = 1;

    localparam int unsigned TCM_DATA_W = 32;
    localparam int unsigned TCM_ADDR_W = 32;
    localparam int unsigned TCM_LAU    = 8;
    localparam int unsigned TCM_BE_W   = TCM_DATA_W / TCM_LAU;

    typedef struct packed {
        logic                  we;
        logic [TCM_ADDR_W-1:0] addr;
        logic [TCM_DATA_W-1:0] wdata;
        logic [TCM_BE_W-1:0]   be;
    } tcm_req_t;

    typedef struct packed {
        logic                  rvalid;
        logic [TCM_DATA_W-1:0] rdata;
        logic                  err;
    } tcm_rsp_t;

    // Address of the highest enabled byte; one extra bit so addr near 2^N cannot wrap.
    function automatic logic [TCM_ADDR_W:0] hi_byte_addr(
        input logic [TCM_ADDR_W-1:0] addr,
        input logic [TCM_BE_W-1:0]   be
    );
        logic [TCM_ADDR_W:0] off;
        off = '0;
        for (int unsigned i = 0; i < TCM_BE_W; i++) begin
            if (be[i]) off = (TCM_ADDR_W+1)'(i);
        end
        return {1'b0, addr} + off;
    endfunction

endpackage

// File: rtl/dtcm_arbiter_if.sv
// dtcm_arbiter_if: requester-side req/gnt/rvalid bus of the data-TCM arbiter.
//   p_req_i/p_we_i/p_addr_i/p_wdata_i/p_be_i : per-port request fields (master drives)
//   p_gnt_o/p_rvalid_o                       : per-port handshake (slave drives)
//   p_rdata_o/p_err_o                        : shared response, qualified by p_rvalid_o
interface dtcm_arbiter_if
    import dtcm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = TCM_DATA_W,
    parameter int unsigned ADDR_WIDTH = TCM_ADDR_W,
    parameter int unsigned LAU        = TCM_LAU
) ();

    localparam int unsigned N_BYTES = DATA_WIDTH / LAU;

    logic [N_PORTS-1:0]                 p_req_i;
    logic [N_PORTS-1:0]                 p_we_i;
    logic [N_PORTS-1:0][ADDR_WIDTH-1:0] p_addr_i;
    logic [N_PORTS-1:0][DATA_WIDTH-1:0] p_wdata_i;
    logic [N_PORTS-1:0][N_BYTES-1:0]    p_be_i;
    logic [N_PORTS-1:0]                 p_gnt_o;
    logic [N_PORTS-1:0]                 p_rvalid_o;
    logic [DATA_WIDTH-1:0]              p_rdata_o;
    logic                               p_err_o;

    modport master (
        output p_req_i, p_we_i, p_addr_i, p_wdata_i, p_be_i,
        input  p_gnt_o, p_rvalid_o, p_rdata_o, p_err_o
    );

    modport slave (
        input  p_req_i, p_we_i, p_addr_i, p_wdata_i, p_be_i,
        output p_gnt_o, p_rvalid_o, p_rdata_o, p_err_o
    );

endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter, combinational grant, registered last-winner pointer.
//   clk, rst_n : clock, async active-low reset
//   req        : request per port
//   gnt        : one-hot grant (combinational), forced 0 while in reset
module rr_arb2
    import dtcm_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_PORTS-1:0] req,
    output logic [N_PORTS-1:0] gnt
);

    logic r_last;
    logic w_last_nxt;

    // Reset to 1 so port 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_last <= 1'b1;
        else        r_last <= w_last_nxt;
    end

    // Tie goes to the port that did not win last; pointer moves only on a grant.
    always_comb begin
        gnt        = '0;
        w_last_nxt = r_last;
        if (rst_n) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = r_last ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
            if (gnt[0])      w_last_nxt = 1'b0;
            else if (gnt[1]) w_last_nxt = 1'b1;
        end
    end

endmodule

// File: rtl/dtcm_arbiter.sv
// dtcm_arbiter: shares one data-TCM port between the LSU (port 0) and debug/DMA (port 1).
//   clk, rst_n : clock, async active-low reset
//   bus        : requester req/gnt/rvalid bus (slave side)
//   mem_*_o    : combinational request to the TCM, zero when nothing is granted
//   mem_data_i : combinational TCM read data, captured at the grant edge
module dtcm_arbiter
    import dtcm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = TCM_DATA_W,
    parameter int unsigned ADDR_WIDTH = TCM_ADDR_W,
    parameter int unsigned LAU        = TCM_LAU,
    parameter int unsigned SIZE_LAU   = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    dtcm_arbiter_if.slave               bus,
    output logic [DATA_WIDTH-1:0]       mem_data_o,
    output logic [ADDR_WIDTH-1:0]       mem_addr_o,
    output logic                        mem_we_o,
    output logic [DATA_WIDTH/LAU-1:0]   mem_be_o,
    input  logic [DATA_WIDTH-1:0]       mem_data_i
);

    localparam int unsigned N_BYTES = DATA_WIDTH / LAU;

    logic [N_PORTS-1:0]    w_gnt;
    logic                  w_any_gnt;
    logic                  w_port;
    tcm_req_t              w_req;
    logic [TCM_ADDR_W:0]   w_hi;
    logic                  w_err;
    logic [DATA_WIDTH-1:0] w_lane_mask;
    logic [DATA_WIDTH-1:0] w_rdata_nxt;

    tcm_rsp_t              r_rsp;
    logic                  r_port;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (bus.p_req_i),
        .gnt   (w_gnt)
    );

    assign w_any_gnt = |w_gnt;

    // Request mux; stays all-zero when nothing is granted.
    always_comb begin
        w_req  = '0;
        w_port = 1'b0;
        for (int unsigned p = 0; p < N_PORTS; p++) begin
            if (w_gnt[p]) begin
                w_port      = 1'(p);
                w_req.we    = bus.p_we_i[p];
                w_req.addr  = bus.p_addr_i[p];
                w_req.wdata = bus.p_wdata_i[p];
                w_req.be    = bus.p_be_i[p];
            end
        end
    end

    // Out of range if the last enabled byte falls past the TCM, or nothing is enabled.
    assign w_hi  = hi_byte_addr(w_req.addr, w_req.be);
    assign w_err = (w_req.be == '0) || (w_hi >= (TCM_ADDR_W+1)'(SIZE_LAU));

    assign mem_we_o   = w_any_gnt & w_req.we & ~w_err;
    assign mem_be_o   = w_req.be;
    assign mem_addr_o = w_req.addr;
    assign mem_data_o = w_req.wdata;

    // Read data with disabled lanes zeroed; writes and errors respond with zero.
    always_comb begin
        w_lane_mask = '0;
        for (int unsigned b = 0; b < N_BYTES; b++) begin
            w_lane_mask[b*LAU +: LAU] = {LAU{w_req.be[b]}};
        end
        w_rdata_nxt = (w_err || w_req.we) ? '0 : (mem_data_i & w_lane_mask);
    end

    // Response register loads every cycle; reset drops any pending response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp  <= '0;
            r_port <= 1'b0;
        end else begin
            r_rsp.rvalid <= w_any_gnt;
            r_rsp.rdata  <= w_any_gnt ? w_rdata_nxt : '0;
            r_rsp.err    <= w_any_gnt & w_err;
            r_port       <= w_port;
        end
    end

    assign bus.p_gnt_o       = w_gnt;
    assign bus.p_rvalid_o[0] = r_rsp.rvalid & ~r_port;
    assign bus.p_rvalid_o[1] = r_rsp.rvalid &  r_port;
    assign bus.p_rdata_o     = r_rsp.rdata;
    assign bus.p_err_o       = r_rsp.err;

endmodule

// File: tb/tb_dtcm_arbiter.sv
// tb_dtcm_arbiter: directed bench with a byte-array TCM, a transaction-level reference
// model checked every cycle, and literal expectations along the directed sequence.
module tb_dtcm_arbiter;
    import dtcm_pkg::*;

    localparam int SIZE = 1024;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_data_o;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_data_i;

    int n_cmp;
    int n_fail;

    dtcm_arbiter_if bus ();

    dtcm_arbiter #(.SIZE_LAU(SIZE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .mem_data_o (mem_data_o),
        .mem_addr_o (mem_addr_o),
        .mem_we_o   (mem_we_o),
        .mem_be_o   (mem_be_o),
        .mem_data_i (mem_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-addressed TCM: combinational read, write at the rising edge.
    logic [7:0] tcm [SIZE];

    always_comb begin
        mem_data_i = '0;
        for (int b = 0; b < 4; b++) begin
            if (longint'(mem_addr_o) + b < SIZE)
                mem_data_i[b*8 +: 8] = tcm[mem_addr_o[9:0] + 10'(b)];
        end
    end

    always @(posedge clk) begin
        if (mem_we_o) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be_o[b] && (longint'(mem_addr_o) + b < SIZE))
                    tcm[mem_addr_o[9:0] + 10'(b)] <= mem_data_o[b*8 +: 8];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
        end
    endtask

    // Reference model: shadow memory, last winner, and the response due next cycle.
    logic [7:0]  shadow [SIZE];
    int          m_last;
    logic [1:0]  pend_rv;
    logic [31:0] pend_rd;
    logic        pend_err;

    int          g;
    logic [1:0]  egnt;
    logic        m_we;
    logic [31:0] m_a;
    logic [31:0] m_wd;
    logic [3:0]  m_be;
    int          top;
    logic        m_err;
    logic [31:0] n_rd;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_gnt",    bus.p_gnt_o,    0);
            chk("rst_rvalid", bus.p_rvalid_o, 0);
            chk("rst_rdata",  bus.p_rdata_o,  0);
            chk("rst_err",    bus.p_err_o,    0);
            chk("rst_mem_we", mem_we_o,       0);
            m_last   = 1;
            pend_rv  = '0;
            pend_rd  = '0;
            pend_err = 1'b0;
        end else begin
            chk("m_rvalid", bus.p_rvalid_o, pend_rv);
            if (pend_rv != 2'b00) begin
                chk("m_rdata", bus.p_rdata_o, pend_rd);
                chk("m_err",   bus.p_err_o,   pend_err);
            end
            if (bus.p_req_i == 2'b11)      g = (m_last == 1) ? 0 : 1;
            else if (bus.p_req_i == 2'b01) g = 0;
            else if (bus.p_req_i == 2'b10) g = 1;
            else                           g = -1;
            egnt = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
            chk("m_gnt", bus.p_gnt_o, egnt);
            if (g < 0) begin
                chk("m_idle_we",   mem_we_o,   0);
                chk("m_idle_be",   mem_be_o,   0);
                chk("m_idle_addr", mem_addr_o, 0);
                chk("m_idle_data", mem_data_o, 0);
                pend_rv  = '0;
                pend_rd  = '0;
                pend_err = 1'b0;
            end else begin
                m_we = bus.p_we_i[g];
                m_a  = bus.p_addr_i[g];
                m_wd = bus.p_wdata_i[g];
                m_be = bus.p_be_i[g];
                top  = -1;
                for (int i = 0; i < 4; i++) if (m_be[i]) top = i;
                m_err = (top < 0) || (longint'(m_a) + top >= SIZE);
                chk("m_mem_we",   mem_we_o,   m_we && !m_err);
                chk("m_mem_be",   mem_be_o,   m_be);
                chk("m_mem_addr", mem_addr_o, m_a);
                chk("m_mem_data", mem_data_o, m_wd);
                n_rd = '0;
                if (!m_err && !m_we) begin
                    for (int i = 0; i < 4; i++)
                        if (m_be[i]) n_rd[i*8 +: 8] = shadow[m_a + 32'(i)];
                end
                if (!m_err && m_we) begin
                    for (int i = 0; i < 4; i++)
                        if (m_be[i]) shadow[m_a + 32'(i)] = m_wd[i*8 +: 8];
                end
                pend_rv  = egnt;
                pend_rd  = n_rd;
                pend_err = m_err;
                m_last   = g;
            end
        end
    end

    task automatic drv(input int p, input bit req, input bit we, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
        bus.p_req_i[p]   = req;
        bus.p_we_i[p]    = we;
        bus.p_addr_i[p]  = a;
        bus.p_wdata_i[p] = d;
        bus.p_be_i[p]    = be;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int nbad;

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        for (int i = 0; i < SIZE; i++) begin
            tcm[i]    = 8'h00;
            shadow[i] = 8'h00;
        end
        rst_n = 1'b0;
        drv(0, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rvalid", bus.p_rvalid_o, 0);
        chk("reset_mem_we", mem_we_o, 0);

        // Port 0 write then read back
        tick(); rst_n = 1'b1; drv(0, 1, 1, 32'h10, 32'hA0B0C0D0, 4'hF);
        @(negedge clk); chk("wr_gnt", bus.p_gnt_o, 2'b01); chk("wr_mem_we", mem_we_o, 1);
        tick(); drv(0, 1, 0, 32'h10, 32'h0, 4'hF);
        @(negedge clk); chk("rd_gnt", bus.p_gnt_o, 2'b01); chk("wr_rvalid", bus.p_rvalid_o, 2'b01);
        chk("wr_err", bus.p_err_o, 0);
        tick(); drv(0, 0, 0, 0, 0, 0); drv(1, 1, 0, 32'h40, 32'h0, 4'hF);
        @(negedge clk); chk("rd_rvalid", bus.p_rvalid_o, 2'b01);
        chk("rd_rdata", bus.p_rdata_o, 32'hA0B0C0D0);

        // Both ports read every cycle: strict alternation starting at port 0
        drv(0, 1, 0, 32'h10, 32'h0, 4'hF);
        for (int k = 0; k < 6; k++) begin
            tick();
            @(negedge clk);
            chk("alt_gnt", bus.p_gnt_o, (k % 2 == 0) ? 2'b01 : 2'b10);
        end
        tick(); drv(0, 0, 0, 0, 0, 0); drv(1, 0, 0, 0, 0, 0);
        @(negedge clk); chk("alt_last_rvalid", bus.p_rvalid_o, 2'b10);
        chk("alt_last_rdata", bus.p_rdata_o, 32'h0);

        // Port 1 partial write keeps disabled bytes
        tick(); drv(1, 1, 1, 32'h20, 32'hDDCCBBAA, 4'hF);
        tick(); drv(1, 1, 1, 32'h20, 32'h11223344, 4'b0101);
        tick(); drv(1, 1, 0, 32'h20, 32'h0, 4'hF);
        tick(); drv(1, 1, 0, 32'h20, 32'h0, 4'b0011);
        @(negedge clk); chk("be_rdata", bus.p_rdata_o, 32'hDD22BB44);
        chk("be_rvalid", bus.p_rvalid_o, 2'b10);
        tick(); drv(1, 0, 0, 0, 0, 0);
        @(negedge clk); chk("mask_rdata", bus.p_rdata_o, 32'h0000BB44);

        // Upper bound
        tick(); drv(0, 1, 1, 32'd1020, 32'h12345678, 4'hF);
        tick(); drv(0, 1, 1, 32'd1022, 32'h55667788, 4'hF);
        @(negedge clk); chk("oob_mem_we", mem_we_o, 0); chk("oob_gnt", bus.p_gnt_o, 2'b01);
        tick(); drv(0, 1, 0, 32'd1020, 32'h0, 4'hF);
        @(negedge clk); chk("oob_err", bus.p_err_o, 1); chk("oob_rdata", bus.p_rdata_o, 0);
        chk("oob_rvalid", bus.p_rvalid_o, 2'b01);
        tick(); drv(0, 1, 1, 32'd1022, 32'h0000ABCD, 4'b0011);
        @(negedge clk); chk("oob_keep", bus.p_rdata_o, 32'h12345678);
        chk("edge_mem_we", mem_we_o, 1);
        tick(); drv(0, 1, 0, 32'd1020, 32'h0, 4'hF);
        @(negedge clk); chk("edge_err", bus.p_err_o, 0);
        tick(); drv(0, 0, 0, 0, 0, 0);
        @(negedge clk); chk("edge_rdata", bus.p_rdata_o, 32'hABCD5678);

        // Empty byte enable
        tick(); drv(0, 1, 1, 32'h10, 32'hFFFFFFFF, 4'b0000);
        @(negedge clk); chk("be0_mem_we", mem_we_o, 0);
        tick(); drv(0, 1, 0, 32'h10, 32'h0, 4'hF);
        @(negedge clk); chk("be0_err", bus.p_err_o, 1);
        tick(); drv(0, 0, 0, 0, 0, 0);
        @(negedge clk); chk("be0_keep", bus.p_rdata_o, 32'hA0B0C0D0);

        // Reset right after a read grant drops its response
        tick(); drv(0, 1, 0, 32'h10, 32'h0, 4'hF);
        @(negedge clk); chk("pre_rst_gnt", bus.p_gnt_o, 2'b01);
        tick(); rst_n = 1'b0; drv(0, 0, 0, 0, 0, 0);
        @(negedge clk); chk("mid_rst_rvalid", bus.p_rvalid_o, 0);
        chk("mid_rst_rdata", bus.p_rdata_o, 0);
        tick(); drv(0, 1, 0, 32'h10, 32'h0, 4'hF); drv(1, 1, 0, 32'h40, 32'h0, 4'hF);
        @(negedge clk); chk("in_rst_gnt", bus.p_gnt_o, 0);
        tick(); rst_n = 1'b1;
        @(negedge clk); chk("post_rst_tie", bus.p_gnt_o, 2'b01);
        tick(); drv(0, 0, 0, 0, 0, 0); drv(1, 0, 0, 0, 0, 0);
        @(negedge clk); chk("post_rst_rvalid", bus.p_rvalid_o, 2'b01);
        chk("post_rst_rdata", bus.p_rdata_o, 32'hA0B0C0D0);
        tick();

        nbad = 0;
        for (int i = 0; i < SIZE; i++) if (tcm[i] !== shadow[i]) nbad++;
        chk("tcm_contents", nbad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
